// File: rtl/prng_rnd_gearbox.sv
// prng_rnd_gearbox: packs RATIO consecutive IN_W-bit randomness words into one
// OUT_W-bit word for masked-gadget randomness inputs. The first accepted word
// of a group lands in the LSBs. out_rnd comes straight from buffer flops so
// that downstream gadgets never see combinational glitches.
module prng_rnd_gearbox #(
    parameter int IN_W  = 32,
    parameter int RATIO = 4,
    localparam int OUT_W = IN_W * RATIO,
    localparam int CW    = $clog2(RATIO + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_rnd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_rnd,
    output logic [CW-1:0]    level
);

    localparam logic [CW-1:0] FULL_CNT = CW'(RATIO);

    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic [CW-1:0]   wr_idx;
    logic            full;
    logic            in_xfer;
    logic            out_xfer;
    logic [IN_W-1:0] slot_q [RATIO];
    logic [IN_W-1:0] slot_d [RATIO];

    // Handshake decode; in_ready is the only input-to-output combinational path.
    // It is also held low while rst is high so nothing is accepted during reset.
    always_comb begin
        full      = (cnt_q == FULL_CNT);
        in_ready  = !rst && !flush && ((cnt_q < FULL_CNT) || out_ready);
        in_xfer   = in_valid && in_ready;
        out_xfer  = full && out_ready;
        // A simultaneous drain and fill restarts the group at slot 0.
        wr_idx    = out_xfer ? '0 : cnt_q;
        out_valid = full;
        level     = cnt_q;
    end

    // Next-count: flush wins, then combined transfer, then single transfers.
    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (in_xfer && out_xfer) begin
            cnt_d = CW'(1);
        end else if (in_xfer) begin
            cnt_d = cnt_q + CW'(1);
        end else if (out_xfer) begin
            cnt_d = '0;
        end
    end

    // Occupancy counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < RATIO; gi++) begin : g_slot
            // Slot load: only the addressed slot captures an accepted word;
            // stale slots keep their contents since they are never exposed.
            always_comb begin
                slot_d[gi] = slot_q[gi];
                if (in_xfer && (wr_idx == CW'(gi))) begin
                    slot_d[gi] = in_rnd;
                end
            end

            // Slot register, cleared only by reset.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    slot_q[gi] <= '0;
                end else begin
                    slot_q[gi] <= slot_d[gi];
                end
            end

            assign out_rnd[gi*IN_W +: IN_W] = slot_q[gi];
        end
    endgenerate

endmodule

// File: tb/tb_prng_rnd_gearbox.sv
// Directed bench for prng_rnd_gearbox (IN_W = 8, RATIO = 4). A small reference
// model predicts handshakes; packed words are queued when a group completes
// and compared when the bench sees an output transfer.
module tb_prng_rnd_gearbox;

    localparam int IN_W  = 8;
    localparam int RATIO = 4;
    localparam int OUT_W = IN_W * RATIO;
    localparam int CW    = $clog2(RATIO + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IN_W-1:0]  in_rnd = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] out_rnd;
    logic [CW-1:0]    level;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    logic [IN_W-1:0]  m_buf [RATIO];
    int               m_cnt = 0;
    logic [OUT_W-1:0] exp_q [$];

    prng_rnd_gearbox #(.IN_W(IN_W), .RATIO(RATIO)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rnd    (in_rnd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rnd   (out_rnd),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive at the falling edge, check, update the model,
    // then advance to the next falling edge.
    task automatic step(input logic iv, input logic [IN_W-1:0] din, input logic ordy, input logic fl);
        logic             exp_rdy;
        logic             ix;
        logic             ox;
        logic [OUT_W-1:0] packed_w;
        in_valid  = iv;
        in_rnd    = din;
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_rdy = !fl && ((m_cnt < RATIO) || ordy);
        ix = iv && exp_rdy;
        ox = (m_cnt == RATIO) && ordy;
        chk("in_ready", OUT_W'(in_ready), OUT_W'(exp_rdy));
        chk("level", OUT_W'(level), OUT_W'(m_cnt));
        chk("out_valid", OUT_W'(out_valid), OUT_W'(m_cnt == RATIO));
        if (m_cnt == RATIO) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL scoreboard: observed output with empty queue, expected none");
            end else begin
                chk("out_rnd", out_rnd, exp_q[0]);
                if (ox) begin
                    packed_w = exp_q.pop_front();
                    $display("tb: out transfer %h", packed_w);
                end
            end
        end
        if (fl) begin
            if (m_cnt == RATIO && !ox && exp_q.size() != 0) begin
                packed_w = exp_q.pop_back();
            end
            m_cnt = 0;
        end else if (ix && ox) begin
            m_buf[0] = din;
            m_cnt = 1;
        end else if (ix) begin
            m_buf[m_cnt] = din;
            m_cnt++;
            if (m_cnt == RATIO) begin
                for (int k = 0; k < RATIO; k++) packed_w[k*IN_W +: IN_W] = m_buf[k];
                exp_q.push_back(packed_w);
            end
        end else if (ox) begin
            m_cnt = 0;
        end
        if (iv) $display("tb: in %h ready=%0d flush=%0d", din, exp_rdy, fl);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted between edges, checked before the next edge.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_level", OUT_W'(level), '0);
        chk("rst_out_valid", OUT_W'(out_valid), '0);
        chk("rst_in_ready", OUT_W'(in_ready), '0);
        chk("rst_out_rnd", out_rnd, '0);
        m_cnt = 0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        $display("tb: async reset applied");
    endtask

    initial begin
        // Reset state.
        #2;
        chk("reset_level", OUT_W'(level), '0);
        chk("reset_out_valid", OUT_W'(out_valid), '0);
        chk("reset_in_ready", OUT_W'(in_ready), '0);
        chk("reset_out_rnd", out_rnd, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic packing, then backpressure with in_valid held high.
        step(1, 8'h11, 0, 0);
        step(1, 8'h22, 0, 0);
        step(1, 8'h33, 0, 0);
        step(1, 8'h44, 0, 0);
        chk("pack_word", out_rnd, 32'h44332211);
        for (int i = 0; i < 10; i++) step(1, 8'hEE, 0, 0);

        // Simultaneous drain and fill: 0x55 starts the next group.
        step(1, 8'h55, 1, 0);
        chk("simul_level", OUT_W'(level), 1);
        step(1, 8'h66, 0, 0);
        step(1, 8'h77, 0, 0);
        step(1, 8'h88, 0, 0);
        chk("simul_word", out_rnd, 32'h88776655);
        step(0, 8'h00, 1, 0);

        // Flush discards a partial group.
        step(1, 8'hAA, 0, 0);
        step(1, 8'hBB, 0, 0);
        step(1, 8'hCC, 0, 1);
        step(1, 8'h01, 0, 0);
        step(1, 8'h02, 0, 0);
        step(1, 8'h03, 0, 0);
        step(1, 8'h04, 0, 0);
        chk("flush_word", out_rnd, 32'h04030201);
        // Flush coinciding with an output transfer: word still delivered.
        step(0, 8'h00, 1, 1);
        chk("flush_drain_level", OUT_W'(level), 0);

        // Streaming at full throughput.
        for (int i = 0; i < 16; i++) step(1, 8'(i), 1, 0);
        step(0, 8'h00, 1, 0);
        chk("stream_queue_empty", OUT_W'(exp_q.size()), 0);

        // Asynchronous reset mid-group at level 2.
        step(1, 8'hD1, 0, 0);
        step(1, 8'hD2, 0, 0);
        async_reset();
        step(1, 8'hA1, 0, 0);
        step(1, 8'hA2, 0, 0);
        step(1, 8'hA3, 0, 0);
        step(1, 8'hA4, 0, 0);
        chk("post_reset_word", out_rnd, 32'hA4A3A2A1);
        step(0, 8'h00, 1, 0);
        step(0, 8'h00, 1, 0);
        chk("final_queue_empty", OUT_W'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
